// File: rtl/perceptron_layer_ctrl_pkg.sv
// Shared types and constants for the perceptron layer sequencer.
package perceptron_pkg;
    // Datapath width: input vector, each weight, bias and result.
    localparam int DW               = 8;
    // Weight-memory words occupied by one neuron: 8 weights then the bias.
    localparam int WORDS_PER_NEURON = 9;
    // Word offset (and fetch slot) of the bias inside a neuron's block.
    localparam int BIAS_SLOT        = 8;
    // Width of the phase counter shared by FETCH and COMPUTE.
    localparam int PHASE_W          = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } state_t;
endpackage

// File: rtl/perceptron_layer_ctrl.sv
// Sequencer that runs one shared registered perceptron over every neuron of
// a layer: fetch weights and bias, wait out the perceptron latency, then hand
// the result downstream over valid/ready.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. in_ready is only high in IDLE; out_valid is only high in EMIT and
// out_data/out_idx/out_last stay frozen until out_ready is seen.
module perceptron_layer_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int PE_LAT    = 1,
    parameter int AW        = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_vec,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_rd_data,
    output logic [DW-1:0]   pe_in,
    output logic [8*DW-1:0] pe_weights,
    output logic [DW-1:0]   pe_bias,
    input  logic [DW-1:0]   pe_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      out_idx,
    output logic            out_last,
    output logic            busy
);

    // Phase on which the last read (the bias word) is issued.
    localparam logic [PHASE_W-1:0] LAST_READ    = PHASE_W'(BIAS_SLOT);
    // Phase on which the bias read data arrives; FETCH ends here.
    localparam logic [PHASE_W-1:0] LAST_FETCH   = PHASE_W'(BIAS_SLOT + 1);
    // COMPUTE spans phases 0..PE_LAT; pe_out is sampled at the end of the last.
    localparam logic [PHASE_W-1:0] LAST_COMPUTE = PHASE_W'(PE_LAT);
    localparam logic [3:0]         LAST_K       = 4'(N_NEURONS - 1);
    localparam logic [AW-1:0]      BASE_STEP    = AW'(WORDS_PER_NEURON);

    state_t             state;
    logic [PHASE_W-1:0] phase;   // cycle within FETCH or COMPUTE
    logic [3:0]         k;       // current neuron index
    logic [AW-1:0]      base;    // first word of neuron k, stepped by 9

    // Layer FSM with all outputs registered; reset returns to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            k          <= '0;
            base       <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            pe_in      <= '0;
            pe_weights <= '0;
            pe_bias    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pe_in     <= in_vec;
                        k         <= '0;
                        base      <= '0;
                        phase     <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    // Read data lags the strobe by one cycle, so phase p
                    // carries the word requested on phase p-1.
                    for (int j = 0; j < BIAS_SLOT; j++) begin
                        if (phase == PHASE_W'(j + 1)) begin
                            pe_weights[DW*j +: DW] <= mem_rd_data;
                        end
                    end
                    if (phase == LAST_FETCH) begin
                        pe_bias <= mem_rd_data;
                    end

                    if (phase < LAST_READ) begin
                        mem_addr <= base + AW'(phase) + AW'(1);
                    end else begin
                        mem_rd_en <= 1'b0;
                    end

                    if (phase == LAST_FETCH) begin
                        phase <= '0;
                        state <= COMPUTE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                COMPUTE: begin
                    // Operands are untouched here; only the result is taken.
                    if (phase == LAST_COMPUTE) begin
                        out_data  <= pe_out;
                        out_idx   <= k;
                        out_last  <= (k == LAST_K);
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            k         <= k + 1'b1;
                            base      <= base + BASE_STEP;
                            mem_addr  <= base + BASE_STEP;
                            mem_rd_en <= 1'b1;
                            phase     <= '0;
                            state     <= FETCH;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_layer_ctrl.sv
// Bench for perceptron_layer_ctrl: a registered weight RAM and a registered
// perceptron surround the controller; results are compared with a reference
// computed directly from RAM contents and the input vector.
module tb_perceptron_layer_ctrl;
    localparam int N_NEURONS = 4;
    localparam int PE_LAT    = 1;
    localparam int AW        = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_vec;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = 8'h00;
    logic [7:0]    pe_in;
    logic [63:0]   pe_weights;
    logic [7:0]    pe_bias;
    logic [7:0]    pe_out = 8'h00;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [3:0]    out_idx;
    logic          out_last;
    logic          busy;

    logic [7:0]    ram [0:63];
    logic [7:0]    exp_q [$];
    logic [AW-1:0] addr_log [$];
    int            checks = 0;
    int            errors = 0;

    perceptron_layer_ctrl #(
        .N_NEURONS(N_NEURONS),
        .PE_LAT   (PE_LAT),
        .AW       (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .pe_in      (pe_in),
        .pe_weights (pe_weights),
        .pe_bias    (pe_bias),
        .pe_out     (pe_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Weight RAM: one-cycle registered read
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    // Registered perceptron: bias plus weights of set input bits, mod 256
    function automatic logic [7:0] pe_fn(input logic [7:0] x, input logic [63:0] w,
                                         input logic [7:0] b);
        logic [7:0] s;
        s = b;
        for (int j = 0; j < 8; j++) if (x[j]) s = s + w[8*j +: 8];
        return s;
    endfunction
    always @(posedge clk) pe_out <= pe_fn(pe_in, pe_weights, pe_bias);

    // Address log of every read strobe
    always @(negedge clk) if (mem_rd_en) addr_log.push_back(mem_addr);

    // Reference: neuron k uses words 9k..9k+7 as weights and 9k+8 as bias
    function automatic logic [7:0] ref_result(input logic [7:0] vec, input int k);
        int acc;
        acc = int'(ram[9*k+8]);
        for (int j = 0; j < 8; j++) if (vec[j]) acc = acc + int'(ram[9*k+j]);
        return 8'(acc % 256);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_idx", out_idx, 4'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_pe_in", pe_in, 8'h00);
        check("rst_pe_weights", pe_weights, 64'h0);
        check("rst_pe_bias", pe_bias, 8'h00);
    endtask

    task automatic fill_inc();
        for (int a = 0; a < 64; a++) ram[a] = 8'(a + 1);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 64; a++) ram[a] = 8'($urandom_range(0, 255));
    endtask

    // Driver + scoreboard for one layer. stall_k/abort_k < 0 disable them.
    task automatic run_layer(input logic [7:0] vec, input int stall_k, input int stall_len,
                             input bit inject, input int abort_k, output logic [7:0] first_data);
        int n;
        bit got;
        logic [7:0] exp_d;
        exp_q.delete();
        for (int k = 0; k < N_NEURONS; k++) exp_q.push_back(ref_result(vec, k));
        addr_log.delete();
        first_data = 8'h00;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec   = vec;
        for (int k = 0; k < N_NEURONS; k++) begin
            exp_d = exp_q.pop_front();
            n = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                if (k == 0 && n == 1) begin
                    in_valid = 1'b0;
                    in_vec   = 8'h00;
                end
                if (inject && k == 0 && n == 3) begin
                    check("in_ready_while_busy", in_ready, 1'b0);
                    in_valid = 1'b1;
                    in_vec   = 8'hFF;
                end
                if (inject && k == 0 && n == 4) in_valid = 1'b0;
                if (k == abort_k && n == 3) begin
                    check("abort_in_fetch", mem_rd_en, 1'b1);
                    #2 rst_n = 1'b0;
                    #1 check_reset_state();
                    @(negedge clk);
                    rst_n = 1'b1;
                    exp_q.delete();
                    return;
                end
                got = out_valid;
            end
            check("out_valid_seen", got, 1'b1);
            check("latency", n, 13);
            check("out_data", out_data, exp_d);
            check("out_idx", out_idx, k);
            check("out_last", out_last, (k == N_NEURONS - 1));
            if (k == 0) first_data = out_data;
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_out_valid", out_valid, 1'b1);
                    check("stall_out_data", out_data, exp_d);
                    check("stall_out_idx", out_idx, k);
                    check("stall_mem_rd_en", mem_rd_en, 1'b0);
                    check("stall_in_ready", in_ready, 1'b0);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("end_in_ready", in_ready, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_out_valid", out_valid, 1'b0);
        check("end_pe_in_held", pe_in, vec);
        check("addr_count", addr_log.size(), 9 * N_NEURONS);
        for (int i = 0; i < addr_log.size() && i < 9 * N_NEURONS; i++)
            check("addr_seq", addr_log[i], i);
    endtask

    initial begin
        logic [7:0] fd;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        fill_inc();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Incrementing RAM, single input bit
        run_layer(8'h01, -1, 0, 1'b0, -1, fd);
        check("inc_first_result", fd, 8'h0A);

        // Sum wraps modulo 256
        fill_rand();
        ram[0] = 8'h80;
        ram[1] = 8'h80;
        for (int a = 2; a < 8; a++) ram[a] = 8'h00;
        ram[8] = 8'h01;
        run_layer(8'h03, -1, 0, 1'b0, -1, fd);
        check("wrap_result", fd, 8'h01);

        // Backpressure on neuron 1 for 20 cycles
        fill_rand();
        run_layer(8'($urandom_range(0, 255)), 1, 20, 1'b0, -1, fd);

        // Second vector offered while busy is ignored
        fill_rand();
        run_layer(8'h5A, -1, 0, 1'b1, -1, fd);

        // Reset in the middle of neuron 2's fetch, then a clean layer
        run_layer(8'hC3, -1, 0, 1'b0, 2, fd);
        run_layer(8'h96, -1, 0, 1'b0, -1, fd);

        // Randomized layers
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run_layer(8'($urandom_range(0, 255)), int'($urandom_range(0, 4)) - 1,
                      int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), -1, fd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
